// File: rtl/btb_pkg.sv
// Shared helpers for the branch target buffer: index/tag geometry, counter
// initial/allocation values and the counter update operation.
package btb_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_t;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Lowest PC bit used for indexing: compressed code is halfword aligned.
  function automatic int idx_base(input int rvc);
    return (rvc != 0) ? 1 : 2;
  endfunction

  function automatic int tag_lo(input int entries, input int rvc);
    return idx_base(rvc) + idx_w(entries);
  endfunction

  // Weakly not-taken after reset, weakly taken on allocation.
  function automatic int cnt_init(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic int cnt_alloc(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter step: returns the next value, never wrapping.
module sat_counter
  import btb_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  cnt_op_t      op,
  output logic [W-1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    case (op)
      CNT_INC: if (cnt != '1) cnt_next = cnt + W'(1);
      CNT_DEC: if (cnt != '0) cnt_next = cnt - W'(1);
      default: cnt_next = cnt;
    endcase
  end

endmodule

// File: rtl/btb_param.sv
// Branch target buffer with saturating-counter direction prediction: stage-1
// lookup, stage-3 resolve/update, mispredict flush and perf counters.
module btb_param
  import btb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8,
  parameter int RVC     = 1,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memory_stall,
  input  logic              L_W,
  input  logic [31:0]       instructionPC_1,
  output logic              taken,
  output logic [31:0]       branchPC,
  output logic              flush,
  input  logic              is_branchInst_3,
  input  logic [31:0]       instructionPC_3,
  input  logic              is_compressed_3,
  input  logic              taken_3,
  input  logic [31:0]       target_3,
  input  logic              prev_taken_3,
  input  logic [31:0]       prev_target_3,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IW = idx_w(ENTRIES);
  localparam int IB = idx_base(RVC);
  localparam int TL = tag_lo(ENTRIES, RVC);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(cnt_init(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_alloc(CNT_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t           mem [ENTRIES];
  entry_t           e_1, e_3;
  logic [IW-1:0]    idx_1, idx_3;
  logic [TAG_W-1:0] tag_1, tag_3;
  logic             hit_1, hit_3, mis, upd;
  logic [31:0]      fall_through;
  logic [CNT_W-1:0] cnt_next;
  cnt_op_t          cnt_op;
  logic             unused_pc_bits;

  // Bits outside the index/tag fields are intentionally ignored.
  assign unused_pc_bits = ^{instructionPC_1, instructionPC_3};

  assign idx_1 = instructionPC_1[IB +: IW];
  assign tag_1 = instructionPC_1[TL +: TAG_W];
  assign idx_3 = instructionPC_3[IB +: IW];
  assign tag_3 = instructionPC_3[TL +: TAG_W];
  assign e_1   = mem[idx_1];
  assign e_3   = mem[idx_3];

  assign hit_1 = L_W & e_1.valid & (e_1.tag == tag_1);
  assign hit_3 = e_3.valid & (e_3.tag == tag_3);

  assign mis = is_branchInst_3 &
               ((taken_3 != prev_taken_3) |
                (taken_3 & prev_taken_3 & (target_3 != prev_target_3)));
  assign flush = mis;
  assign taken = hit_1 & e_1.cnt[CNT_W-1] & ~flush;

  assign fall_through = instructionPC_3 +
                        (((RVC != 0) && is_compressed_3) ? 32'd2 : 32'd4);

  always_comb begin
    branchPC = 32'd0;
    if (flush) branchPC = taken_3 ? target_3 : fall_through;
    else if (taken) branchPC = e_1.target;
  end

  always_comb begin
    cnt_op = CNT_HOLD;
    if (hit_3) cnt_op = taken_3 ? CNT_INC : CNT_DEC;
  end

  sat_counter #(.W(CNT_W)) u_sat_counter (
    .cnt      (e_3.cnt),
    .op       (cnt_op),
    .cnt_next (cnt_next)
  );

  assign upd = is_branchInst_3 & ~memory_stall;

  // Lookup reads mem directly, so a same-cycle update is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, cnt: CNT_INIT};
      end
    end else if (upd) begin
      if (hit_3) begin
        mem[idx_3].cnt <= cnt_next;
        if (taken_3) mem[idx_3].target <= target_3;
      end else if (taken_3) begin
        mem[idx_3] <= '{valid: 1'b1, tag: tag_3, target: target_3, cnt: CNT_ALLOC};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (!memory_stall) begin
      if (is_branchInst_3) perf_branches <= perf_branches + PERF_W'(1);
      if (mis)             perf_mispred  <= perf_mispred + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_btb_param.sv
// Directed vector bench for btb_param with default parameters
// (32 entries, 2-bit counters, 8-bit tag, RVC on).
module tb_btb_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memory_stall;
  logic        L_W;
  logic [31:0] instructionPC_1;
  logic        taken;
  logic [31:0] branchPC;
  logic        flush;
  logic        is_branchInst_3;
  logic [31:0] instructionPC_3;
  logic        is_compressed_3;
  logic        taken_3;
  logic [31:0] target_3;
  logic        prev_taken_3;
  logic [31:0] prev_target_3;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;

  int n_pass = 0;
  int n_total = 0;
  int exp_br = 0;
  int exp_mis = 0;

  always #5 clk = ~clk;

  btb_param #(.ENTRIES(32), .CNT_W(2), .TAG_W(8), .RVC(1), .PERF_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .memory_stall    (memory_stall),
    .L_W             (L_W),
    .instructionPC_1 (instructionPC_1),
    .taken           (taken),
    .branchPC        (branchPC),
    .flush           (flush),
    .is_branchInst_3 (is_branchInst_3),
    .instructionPC_3 (instructionPC_3),
    .is_compressed_3 (is_compressed_3),
    .taken_3         (taken_3),
    .target_3        (target_3),
    .prev_taken_3    (prev_taken_3),
    .prev_target_3   (prev_target_3),
    .perf_branches   (perf_branches),
    .perf_mispred    (perf_mispred)
  );

  typedef struct {
    logic        lw;
    logic [31:0] pc1;
    logic        br;
    logic [31:0] pc3;
    logic        comp;
    logic        t3;
    logic [31:0] tgt3;
    logic        pt3;
    logic [31:0] ptgt3;
    logic        e_taken;
    logic [31:0] e_bpc;
    logic        e_flush;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic lw, logic [31:0] pc1, logic br, logic [31:0] pc3,
                              logic comp, logic t3, logic [31:0] tgt3, logic pt3,
                              logic [31:0] ptgt3, logic e_taken, logic [31:0] e_bpc,
                              logic e_flush);
    vec_t v;
    v.lw = lw; v.pc1 = pc1; v.br = br; v.pc3 = pc3; v.comp = comp; v.t3 = t3;
    v.tgt3 = tgt3; v.pt3 = pt3; v.ptgt3 = ptgt3;
    v.e_taken = e_taken; v.e_bpc = e_bpc; v.e_flush = e_flush;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    L_W = v.lw; instructionPC_1 = v.pc1;
    is_branchInst_3 = v.br; instructionPC_3 = v.pc3; is_compressed_3 = v.comp;
    taken_3 = v.t3; target_3 = v.tgt3; prev_taken_3 = v.pt3; prev_target_3 = v.ptgt3;
  endtask

  task automatic check_outs(input string tag, input logic e_taken, input logic [31:0] e_bpc,
                            input logic e_flush, input int e_br, input int e_mis);
    chk({tag, " taken"}, {31'd0, taken}, {31'd0, e_taken});
    chk({tag, " branchPC"}, branchPC, e_bpc);
    chk({tag, " flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, " perf_branches"}, perf_branches, e_br);
    chk({tag, " perf_mispred"}, perf_mispred, e_mis);
  endtask

  initial begin
    //          lw pc1     br pc3     c  t3 tgt3    pt ptgt3    | tk bpc     fl
    vecs[0]  = mk(1, 'h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0);
    vecs[1]  = mk(1, 'h100, 1, 'h100, 0, 1, 'h200, 0, 'h000, 0, 'h200, 1);
    vecs[2]  = mk(1, 'h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 1, 'h200, 0);
    vecs[3]  = mk(1, 'h180, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0);
    vecs[4]  = mk(1, 'h100, 1, 'h100, 0, 1, 'h300, 1, 'h300, 1, 'h200, 0);
    vecs[5]  = mk(1, 'h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 1, 'h300, 0);
    vecs[6]  = mk(0, 'h106, 1, 'h106, 0, 1, 'h400, 1, 'h400, 0, 'h000, 0);
    vecs[7]  = mk(1, 'h106, 1, 'h106, 0, 0, 'h000, 1, 'h400, 0, 'h10a, 1);
    vecs[8]  = mk(1, 'h106, 1, 'h106, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0);
    vecs[9]  = mk(1, 'h106, 1, 'h106, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0);
    vecs[10] = mk(1, 'h106, 1, 'h106, 0, 1, 'h400, 0, 'h000, 0, 'h400, 1);
    vecs[11] = mk(1, 'h106, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0);
    vecs[12] = mk(1, 'h100, 1, 'h100, 0, 1, 'h300, 1, 'h300, 1, 'h300, 0);
    vecs[13] = mk(1, 'h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 1, 'h300, 0);
    vecs[14] = mk(1, 'h102, 1, 'h102, 1, 0, 'h000, 1, 'h000, 0, 'h104, 1);
    vecs[15] = mk(1, 'h102, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0);
    vecs[16] = mk(0, 'h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0);
    vecs[17] = mk(1, 'h100, 1, 'h100, 0, 1, 'h600, 1, 'h300, 0, 'h600, 1);
    vecs[18] = mk(1, 'h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 1, 'h600, 0);

    rst_n = 1'b0;
    memory_stall = 1'b0;
    drive(vecs[0]);
    #12;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e_taken, vecs[i].e_bpc,
                 vecs[i].e_flush, exp_br, exp_mis);
      if (vecs[i].br) exp_br++;
      if (vecs[i].e_flush) exp_mis++;
    end

    // Taken resolve of an aliasing PC held through a 3-cycle stall.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      drive(mk(1, 'h180, 1, 'h180, 0, 1, 'h500, 0, 'h000, 0, 'h000, 0));
      memory_stall = (c < 3);
      @(negedge clk);
      check_outs($sformatf("stall%0d", c), 1'b0, 32'h500, 1'b1, exp_br, exp_mis);
    end
    exp_br++; exp_mis++;

    // Allocated once at weakly-taken; one not-taken drops it below threshold.
    @(posedge clk);
    #1;
    drive(mk(1, 'h180, 1, 'h180, 0, 0, 'h000, 1, 'h500, 0, 'h000, 0));
    @(negedge clk);
    check_outs("post_stall_nt", 1'b0, 32'h184, 1'b1, exp_br, exp_mis);
    exp_br++; exp_mis++;

    @(posedge clk);
    #1;
    drive(mk(1, 'h180, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0));
    @(negedge clk);
    check_outs("post_stall_lookup", 1'b0, 32'h0, 1'b0, exp_br, exp_mis);

    @(posedge clk);
    #1;
    drive(mk(1, 'h180, 1, 'h180, 0, 1, 'h500, 0, 'h000, 0, 'h000, 0));
    @(negedge clk);
    check_outs("retrain", 1'b0, 32'h500, 1'b1, exp_br, exp_mis);
    exp_br++; exp_mis++;

    @(posedge clk);
    #1;
    drive(mk(1, 'h180, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 'h000, 0));
    @(negedge clk);
    check_outs("retrained_lookup", 1'b1, 32'h500, 1'b0, exp_br, exp_mis);

    // Asynchronous reset mid-cycle clears entries and counters at once.
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 32'h0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_outs("after_reset", 1'b0, 32'h0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
